// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared constants and FSM state type for the CIM weight loader
package cim_pkg;

    localparam int CIM_DATA_W = 24;
    localparam int CIM_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cim_addr_cnt.sv
// rtl/cim_addr_cnt.sv - loadable wrapping write-address counter and remaining-word down-counter
module cim_addr_cnt
    import cim_pkg::*;
#(
    parameter int ADDR_W = CIM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   cnt,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W:0] remaining;

    // The address wraps naturally at the bank boundary; no overflow is flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= base;
            remaining <= cnt;
        end else if (step) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    assign last = (remaining == (ADDR_W + 1)'(1));

endmodule

// File: rtl/cim_weight_loader.sv
// rtl/cim_weight_loader.sv - weight write sequencer for the CIM bank router (option: CIM_LOADER_PINGPONG_EN)
module cim_weight_loader
    import cim_pkg::*;
#(
    parameter int DATA_W = CIM_DATA_W,
    parameter int ADDR_W = CIM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_bank,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              cima,
    output logic [ADDR_W-1:0] WA,
    output logic [DATA_W-1:0] D,
    output logic              WE,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state;
    logic              bank;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              accept;
    logic              hs;

`ifdef CIM_LOADER_PINGPONG_EN
    logic toggle;
    logic unused_start_bank;
    assign unused_start_bank = start_bank;
`endif

    assign accept  = (state == IDLE) && start && (word_cnt != '0);
    assign hs      = (state == LOAD) && s_valid;
    assign s_ready = (state == LOAD);
    assign busy    = (state != IDLE);

    cim_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (hs),
        .base  (base_addr),
        .cnt   (word_cnt),
        .addr  (addr),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            bank  <= 1'b0;
            cima  <= 1'b0;
            WA    <= '0;
            D     <= '0;
            WE    <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
`ifdef CIM_LOADER_PINGPONG_EN
            toggle <= 1'b0;
`endif
        end else begin
            WE   <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_cnt != '0) begin
                            state <= LOAD;
`ifdef CIM_LOADER_PINGPONG_EN
                            bank  <= toggle;
`else
                            bank  <= start_bank;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // A start here is refused but never disturbs the running command.
                    if (start) err <= 1'b1;
                    if (s_valid) begin
                        WE   <= 1'b1;
                        WA   <= addr;
                        D    <= s_data;
                        cima <= bank;
                        if (last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) err <= 1'b1;
                    state <= IDLE;
`ifdef CIM_LOADER_PINGPONG_EN
                    toggle <= ~toggle;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_weight_loader.sv
// tb/tb_cim_weight_loader.sv - directed self-checking bench for cim_weight_loader
`timescale 1ns/1ps
module tb_cim_weight_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start_bank;
    logic [7:0]  base_addr;
    logic [8:0]  word_cnt;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        cima;
    logic [7:0]  WA;
    logic [23:0] D;
    logic        WE;
    logic        busy;
    logic        done;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;
    logic tb_tog = 1'b0;

    always #5 clk = ~clk;

    cim_weight_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_bank (start_bank),
        .base_addr  (base_addr),
        .word_cnt   (word_cnt),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .cima       (cima),
        .WA         (WA),
        .D          (D),
        .WE         (WE),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bank(input logic b);
`ifdef CIM_LOADER_PINGPONG_EN
        return tb_tog;
`else
        return b;
`endif
    endfunction

    task automatic cmd_done();
        tb_tog = ~tb_tog;
    endtask

    task automatic run_cmd(input logic bank, input logic [7:0] base, input logic [8:0] cnt,
                           input logic [23:0] d0);
        logic       eb;
        logic [7:0] ea;
        eb = exp_bank(bank);
        start = 1'b1; start_bank = bank; base_addr = base; word_cnt = cnt;
        s_valid = 1'b1; s_data = d0;
        tick();
        start = 1'b0;
        check("busy_on", busy, 1);
        check("ready_on", s_ready, 1);
        check("we_pre", WE, 0);
        for (int i = 0; i < int'(cnt); i++) begin
            tick();
            s_data = d0 + 24'(i + 1);
            ea = base + 8'(i);
            check("we", WE, 1);
            check("wa", WA, ea);
            check("d", D, d0 + 24'(i));
            check("cima", cima, eb);
            check("done", done, (i == int'(cnt) - 1) ? 1 : 0);
            check("err", err, 0);
        end
        s_valid = 1'b0;
        check("ready_off", s_ready, 0);
        tick();
        check("busy_off", busy, 0);
        check("we_off", WE, 0);
        check("done_off", done, 0);
        cmd_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; start_bank = 1'b0; base_addr = '0; word_cnt = '0;
        s_valid = 1'b0; s_data = '0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_ready", s_ready, 0);
        check("rst_we", WE, 0);
        check("rst_wa", WA, 0);
        check("rst_d", D, 0);
        check("rst_cima", cima, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Basic four-word burst, then a wrapping burst.
        run_cmd(1'b1, 8'h10, 9'd4, 24'hA00001);
        run_cmd(1'b0, 8'hFE, 9'd3, 24'h000100);

        // Zero-length command is rejected.
        start = 1'b1; word_cnt = 9'd0; base_addr = 8'h33; start_bank = 1'b1;
        tick();
        start = 1'b0;
        check("zero_err", err, 1);
        check("zero_busy", busy, 0);
        check("zero_we", WE, 0);
        tick();
        check("zero_err_clr", err, 0);
        check("zero_busy2", busy, 0);

        // Start during LOAD is refused and the running command is unchanged.
        start = 1'b1; start_bank = 1'b0; base_addr = 8'h40; word_cnt = 9'd3;
        s_valid = 1'b1; s_data = 24'hB00000;
        tick();
        start = 1'b0;
        tick();
        check("ov_wa0", WA, 8'h40);
        s_data = 24'hB00001;
        start = 1'b1; start_bank = 1'b1; base_addr = 8'h80; word_cnt = 9'd5;
        tick();
        start = 1'b0;
        s_data = 24'hB00002;
        check("ov_err", err, 1);
        check("ov_wa1", WA, 8'h41);
        check("ov_d1", D, 24'hB00001);
        check("ov_cima", cima, exp_bank(1'b0));
        tick();
        s_valid = 1'b0;
        check("ov_wa2", WA, 8'h42);
        check("ov_done", done, 1);
        check("ov_err_clr", err, 0);
        tick();
        check("ov_idle", busy, 0);
        cmd_done();

        // Gapped stream: writes only follow handshakes.
        start = 1'b1; start_bank = 1'b0; base_addr = 8'h20; word_cnt = 9'd2;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 24'h0000C1;
        tick();
        s_valid = 1'b0;
        check("gap_we0", WE, 1);
        check("gap_wa0", WA, 8'h20);
        tick();
        s_valid = 1'b1; s_data = 24'h0000C2;
        check("gap_we_idle", WE, 0);
        check("gap_wa_hold", WA, 8'h20);
        check("gap_d_hold", D, 24'h0000C1);
        tick();
        s_valid = 1'b0;
        check("gap_we1", WE, 1);
        check("gap_wa1", WA, 8'h21);
        check("gap_done", done, 1);
        tick();
        check("gap_idle", busy, 0);
        cmd_done();

        // Reset mid-burst aborts without done.
        start = 1'b1; start_bank = 1'b1; base_addr = 8'h50; word_cnt = 9'd5;
        s_valid = 1'b1; s_data = 24'hD00000;
        tick();
        start = 1'b0;
        tick();
        s_data = 24'hD00001;
        tick();
        check("ab_wa1", WA, 8'h51);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; s_valid = 1'b0;
        tb_tog = 1'b0;
        check("ab_we", WE, 0);
        check("ab_wa", WA, 0);
        check("ab_d", D, 0);
        check("ab_cima", cima, 0);
        check("ab_busy", busy, 0);
        check("ab_ready", s_ready, 0);
        check("ab_done", done, 0);
        tick();
        check("ab_done2", done, 0);
        run_cmd(1'b1, 8'h60, 9'd2, 24'hE00000);

        // Bank selection across successive single-word commands.
        run_cmd(1'b1, 8'h01, 9'd1, 24'h111111);
        run_cmd(1'b1, 8'h02, 9'd1, 24'h222222);
        run_cmd(1'b1, 8'h03, 9'd1, 24'h333333);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
